// File: rtl/number_pkg.sv
// Shared types and constants for the number spawner: slot states, digit and
// LFSR widths, and small helpers for digit generation.
package number_pkg;

    // Life cycle of one number slot: visible, hit-report cycle, hidden.
    typedef enum logic [1:0] {
        S_ACTIVE = 2'd0,
        S_HIT    = 2'd1,
        S_WAIT   = 2'd2
    } slot_state_t;

    localparam int DIGIT_W = 4;
    localparam int LFSR_W  = 8;

    // Tap mask for x^8 + x^6 + x^5 + x^4 + 1 on a left-shifting register.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

    // Map a raw LFSR state onto a decimal digit 0..9.
    function automatic logic [DIGIT_W-1:0] lfsr_to_digit(input logic [LFSR_W-1:0] value);
        logic [LFSR_W-1:0] remainder;
        remainder = value % LFSR_W'(10);
        return remainder[DIGIT_W-1:0];
    endfunction

    // Digit shown by slot `slot` straight out of reset: 1, 2, 3, ...
    function automatic logic [DIGIT_W-1:0] reset_digit(input int slot);
        int value;
        value = (slot + 1) % 10;
        return value[DIGIT_W-1:0];
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used as the source of respawn digits.
// The tap polynomial is primitive, so a nonzero seed never reaches zero.
module lfsr8
    import number_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              resetN,
    output logic [LFSR_W-1:0] o_state
);

    logic [LFSR_W-1:0] r_state;
    logic              w_feedback;

    assign w_feedback = ^(r_state & LFSR_TAPS);

    // Shift every clock, feeding the XOR of the tapped bits into bit 0.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= SEED;
        end else begin
            r_state <= {r_state[LFSR_W-2:0], w_feedback};
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/number_spawner.sv
// Number spawner: turns collision levels into single-cycle hit pulses,
// hides hit number slots for a number of frames and respawns them with a
// fresh digit from the LFSR. Operand objects only produce touch pulses.
module number_spawner
    import number_pkg::*;
#(
    parameter int                NUMBERS        = 3,
    parameter int                RESPAWN_FRAMES = 60,
    parameter logic [LFSR_W-1:0] LFSR_SEED      = 8'hA5
) (
    input  logic                         clk,
    input  logic                         resetN,
    input  logic                         startOfFrame,
    input  logic [NUMBERS-1:0]           collisionNumber,
    input  logic [1:0]                   collisionOperand,
    output logic [NUMBERS-1:0]           SingleHitPulse,
    output logic [1:0]                   operandHit,
    output logic [NUMBERS*DIGIT_W-1:0]   NumbersToShow,
    output logic [NUMBERS-1:0]           NumberVisible
);

    localparam logic [7:0] RESPAWN_LOAD = 8'(RESPAWN_FRAMES);

    // ------------------------------------------------------------------
    // Edge detection on the collision levels
    // ------------------------------------------------------------------
    logic [NUMBERS-1:0] r_prev_num;
    logic [1:0]         r_prev_op;
    logic [NUMBERS-1:0] w_rise_num;
    logic [1:0]         w_rise_op;

    // Remember last cycle's levels in every state, so an overlap that
    // persists across a respawn does not look like a new touch.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_prev_num <= '0;
            r_prev_op  <= '0;
        end else begin
            r_prev_num <= collisionNumber;
            r_prev_op  <= collisionOperand;
        end
    end

    assign w_rise_num = collisionNumber & ~r_prev_num;
    assign w_rise_op  = collisionOperand & ~r_prev_op;

    // ------------------------------------------------------------------
    // Digit source
    // ------------------------------------------------------------------
    logic [LFSR_W-1:0]  w_lfsr;
    logic [DIGIT_W-1:0] w_new_digit;

    lfsr8 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .resetN  (resetN),
        .o_state (w_lfsr)
    );

    // Slots respawning in the same cycle deliberately share this digit.
    assign w_new_digit = lfsr_to_digit(w_lfsr);

    // ------------------------------------------------------------------
    // Operand touches: plus wins when both rise together
    // ------------------------------------------------------------------
    logic [1:0] r_operand_hit;

    // Register one pulse per operand rising edge; a simultaneous minus
    // rise is dropped so the accumulator never sees two operators at once.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_operand_hit <= 2'b00;
        end else if (w_rise_op[0]) begin
            r_operand_hit <= 2'b01;
        end else begin
            r_operand_hit <= {w_rise_op[1], 1'b0};
        end
    end

    assign operandHit = r_operand_hit;

    // ------------------------------------------------------------------
    // Per-slot hide / respawn state machines
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUMBERS; gi++) begin : g_slot
            slot_state_t        r_state;
            logic [7:0]         r_countdown;
            logic [DIGIT_W-1:0] r_digit;
            logic               r_pulse;
            logic               r_visible;

            // Slot FSM with registered outputs. The digit is held through
            // the hit cycle so the accumulator reads the value that was hit.
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    r_state     <= S_ACTIVE;
                    r_countdown <= '0;
                    r_digit     <= reset_digit(gi);
                    r_pulse     <= 1'b0;
                    r_visible   <= 1'b1;
                end else begin
                    r_pulse <= 1'b0;
                    unique case (r_state)
                        S_ACTIVE: begin
                            r_visible <= 1'b1;
                            if (w_rise_num[gi]) begin
                                r_state <= S_HIT;
                                r_pulse <= 1'b1;
                            end
                        end
                        S_HIT: begin
                            r_countdown <= RESPAWN_LOAD;
                            r_visible   <= 1'b0;
                            r_state     <= S_WAIT;
                        end
                        S_WAIT: begin
                            r_visible <= 1'b0;
                            if (startOfFrame) begin
                                if (r_countdown <= 8'd1) begin
                                    r_digit     <= w_new_digit;
                                    r_countdown <= '0;
                                    r_visible   <= 1'b1;
                                    r_state     <= S_ACTIVE;
                                end else begin
                                    r_countdown <= r_countdown - 8'd1;
                                end
                            end
                        end
                        default: begin
                            r_state   <= S_ACTIVE;
                            r_visible <= 1'b1;
                        end
                    endcase
                end
            end

            assign SingleHitPulse[gi]                       = r_pulse;
            assign NumberVisible[gi]                        = r_visible;
            assign NumbersToShow[gi*DIGIT_W +: DIGIT_W]     = r_digit;
        end
    endgenerate

endmodule

// File: tb/tb_number_spawner.sv
// Scoreboard bench for number_spawner: stimulus pushes expected pulses into
// a queue, a monitor pops and compares whenever the DUT emits a pulse.
module tb_number_spawner;

    localparam int NUMBERS = 3;

    logic                 clk;
    logic                 resetN;
    logic                 startOfFrame;
    logic [NUMBERS-1:0]   collisionNumber;
    logic [1:0]           collisionOperand;
    logic [NUMBERS-1:0]   SingleHitPulse;
    logic [1:0]           operandHit;
    logic [NUMBERS*4-1:0] NumbersToShow;
    logic [NUMBERS-1:0]   NumberVisible;

    number_spawner #(
        .NUMBERS        (NUMBERS),
        .RESPAWN_FRAMES (3),
        .LFSR_SEED      (8'hA5)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .collisionNumber  (collisionNumber),
        .collisionOperand (collisionOperand),
        .SingleHitPulse   (SingleHitPulse),
        .operandHit       (operandHit),
        .NumbersToShow    (NumbersToShow),
        .NumberVisible    (NumberVisible)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, left shift, seed A5.
    logic [7:0] m_lfsr;
    always @(posedge clk or negedge resetN) begin
        if (!resetN) m_lfsr <= 8'hA5;
        else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    typedef struct {
        logic [NUMBERS-1:0] hit;
        logic [1:0]         op;
        int                 slot;
        logic [3:0]         digit;
        int                 cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_hit(input int slot, input logic [3:0] digit);
        exp_t e;
        e.hit = NUMBERS'(1) << slot;
        e.op = 2'b00;
        e.slot = slot;
        e.digit = digit;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic expect_op(input logic [1:0] op);
        exp_t e;
        e.hit = '0;
        e.op = op;
        e.slot = -1;
        e.digit = 4'd0;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    // Monitor: every pulse cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (resetN && (SingleHitPulse != '0 || operandHit != 2'b00)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d hit=%b op=%b", cyc, SingleHitPulse, operandHit);
            end else begin
                exp_t e;
                logic [3:0] dig;
                e = sb.pop_front();
                dig = (e.slot >= 0) ? NumbersToShow[e.slot*4 +: 4] : 4'd0;
                if (SingleHitPulse !== e.hit || operandHit !== e.op || cyc != e.cyc || dig !== e.digit) begin
                    errors++;
                    $display("FAIL pulse actual hit=%b op=%b cyc=%0d digit=%0d required hit=%b op=%b cyc=%0d digit=%0d",
                             SingleHitPulse, operandHit, cyc, dig, e.hit, e.op, e.cyc, e.digit);
                end else begin
                    $display("ok   pulse hit=%b op=%b cyc=%0d digit=%0d", SingleHitPulse, operandHit, cyc, dig);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] exp_d;
        logic       seen;

        resetN = 1'b0;
        startOfFrame = 1'b0;
        collisionNumber = '0;
        collisionOperand = 2'b00;
        tick(3);
        resetN = 1'b1;
        tick(1);

        // Reset state
        check("reset_visible", 32'(NumberVisible), 32'h7);
        check("reset_digits", 32'(NumbersToShow), 32'h321);
        check("reset_pulses", {27'd0, SingleHitPulse, operandHit}, 32'h0);

        // Single hit on slot 1, held for 5 cycles
        collisionNumber[1] = 1'b1;
        expect_hit(1, 4'd2);
        tick(5);
        collisionNumber[1] = 1'b0;
        tick(1);
        check("slot1_hidden", 32'(NumberVisible[1]), 32'h0);

        // Hit slot 0 and keep the overlap held through the respawn
        collisionNumber[0] = 1'b1;
        expect_hit(0, 4'd1);
        tick(3);
        exp_d = 4'd0;
        for (int p = 1; p <= 3; p++) begin
            startOfFrame = 1'b1;
            exp_d = 4'(m_lfsr % 8'd10);
            tick(1);
            startOfFrame = 1'b0;
            if (p == 2) check("slot0_hidden_after_2", 32'(NumberVisible[0]), 32'h0);
            if (p == 3) begin
                check("slot0_visible_after_3", 32'(NumberVisible[0]), 32'h1);
                check("slot0_new_digit", 32'(NumbersToShow[3:0]), 32'(exp_d));
                check("slot1_visible", 32'(NumberVisible[1]), 32'h1);
                check("slot1_shared_digit", 32'(NumbersToShow[7:4]), 32'(exp_d));
            end
            tick(2);
        end

        // Still overlapping after respawn: no new hit
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            seen = seen | SingleHitPulse[0];
            tick(1);
        end
        check("held_overlap_no_hit", 32'(seen), 32'h0);

        // Leave for one cycle and re-enter: one hit with the respawned digit
        collisionNumber[0] = 1'b0;
        tick(1);
        collisionNumber[0] = 1'b1;
        expect_hit(0, exp_d);
        tick(3);
        collisionNumber[0] = 1'b0;
        tick(2);

        // Operand priority
        collisionOperand = 2'b11;
        expect_op(2'b01);
        tick(3);
        collisionOperand = 2'b01;
        tick(1);
        collisionOperand = 2'b11;
        expect_op(2'b10);
        tick(3);
        collisionOperand = 2'b00;
        tick(2);

        // Reset while slot 2 is waiting
        collisionNumber[2] = 1'b1;
        expect_hit(2, 4'd3);
        tick(3);
        collisionNumber[2] = 1'b0;
        tick(1);
        check("slot2_hidden", 32'(NumberVisible[2]), 32'h0);
        resetN = 1'b0;
        #1;
        check("async_reset_visible", 32'(NumberVisible), 32'h7);
        check("async_reset_digits", 32'(NumbersToShow), 32'h321);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        tick(1);

        // LFSR restarted from the seed: respawn digit follows the model
        collisionNumber[2] = 1'b1;
        expect_hit(2, 4'd3);
        tick(2);
        collisionNumber[2] = 1'b0;
        tick(2);
        for (int p = 1; p <= 3; p++) begin
            startOfFrame = 1'b1;
            exp_d = 4'(m_lfsr % 8'd10);
            tick(1);
            startOfFrame = 1'b0;
            tick(1);
        end
        check("reload_visible", 32'(NumberVisible[2]), 32'h1);
        check("reload_digit", 32'(NumbersToShow[11:8]), 32'(exp_d));

        tick(3);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
